// File: rtl/pcap_capture_pkg.sv
// Shared types and constants for the pcap position-capture path.
package pcap_capture_pkg;

  localparam int unsigned ERR_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ENABLED,
    FLUSH
  } state_t;

  localparam logic [ERR_W-1:0] ERR_OK      = 2'd0;
  localparam logic [ERR_W-1:0] ERR_OVERRUN = 2'd1;
  localparam logic [ERR_W-1:0] ERR_DISARM  = 2'd2;

  localparam logic FRAMING_DELTA = 1'b0;
  localparam logic FRAMING_LATCH = 1'b1;

endpackage

// File: rtl/pcap_sample_serialiser.sv
// Holds one captured sample and streams its masked channels, lowest index first,
// over a registered valid/ready word interface.
module pcap_sample_serialiser #(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned DW    = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [NCHAN*DW-1:0] data_i,
  input  logic [NCHAN-1:0]    mask_i,
  output logic [DW-1:0]       dat_o,
  output logic                dat_valid_o,
  input  logic                dat_ready_i,
  output logic                busy_c
);

  localparam int unsigned IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [DW-1:0]    data_q [NCHAN];
  logic [NCHAN-1:0] pend_q;
  logic [IW-1:0]    sel_c;
  logic             found_c;

  // Lowest pending channel wins.
  always_comb begin
    sel_c   = '0;
    found_c = 1'b0;
    for (int k = 0; k < NCHAN; k++) begin
      if (pend_q[k] && !found_c) begin
        sel_c   = IW'(k);
        found_c = 1'b1;
      end
    end
  end

  assign busy_c = found_c || dat_valid_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < NCHAN; k++) data_q[k] <= '0;
      pend_q      <= '0;
      dat_o       <= '0;
      dat_valid_o <= 1'b0;
    end else if (clear_i) begin
      pend_q      <= '0;
      dat_valid_o <= 1'b0;
    end else if (load_i) begin
      for (int k = 0; k < NCHAN; k++) data_q[k] <= data_i[k*DW +: DW];
      pend_q <= mask_i;
    end else if (!dat_valid_o || dat_ready_i) begin
      // Output register refills only once the current word has been taken.
      if (found_c) begin
        dat_o         <= data_q[sel_c];
        dat_valid_o   <= 1'b1;
        pend_q[sel_c] <= 1'b0;
      end else begin
        dat_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcap_frame_capture.sv
// Arm/enable/capture sequencing, per-channel framing and sample counting for the
// pcap position path; captured samples are handed to the word serialiser.
module pcap_frame_capture
  import pcap_capture_pkg::*;
#(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                arm_i,
  input  logic                disarm_i,
  input  logic                enable_i,
  input  logic                frame_i,
  input  logic                capture_i,
  input  logic [NCHAN*DW-1:0] posn_i,
  input  logic [NCHAN-1:0]    capture_mask_i,
  input  logic [NCHAN-1:0]    framing_mask_i,
  input  logic                framing_enable_i,
  input  logic                framing_mode_i,
  output logic [DW-1:0]       dat_o,
  output logic                dat_valid_o,
  input  logic                dat_ready_i,
  output logic                active_o,
  output logic                done_o,
  output logic [1:0]          err_o,
  output logic [CNT_W-1:0]    sample_count_o
);

  state_t              state_q, state_d;
  logic                enable_prev, frame_prev, capture_prev;
  logic                enable_rise_c, enable_fall_c, frame_rise_c, capture_rise_c;
  logic                load_c, clear_c, done_c, arm_c, busy_c;
  logic [ERR_W-1:0]    err_d;
  logic [DW-1:0]       frame_latch_q [NCHAN];
  logic [NCHAN*DW-1:0] snap_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      enable_prev  <= 1'b0;
      frame_prev   <= 1'b0;
      capture_prev <= 1'b0;
    end else begin
      enable_prev  <= enable_i;
      frame_prev   <= frame_i;
      capture_prev <= capture_i;
    end
  end

  assign enable_rise_c  = enable_i && !enable_prev;
  assign enable_fall_c  = !enable_i && enable_prev;
  assign frame_rise_c   = frame_i && !frame_prev;
  assign capture_rise_c = capture_i && !capture_prev;

  // Snapshot reads the latch before this cycle's frame edge can update it.
  always_ff @(posedge clk_i) begin
    if (reset_i || arm_c) begin
      for (int k = 0; k < NCHAN; k++) frame_latch_q[k] <= '0;
    end else if (frame_rise_c) begin
      for (int k = 0; k < NCHAN; k++) frame_latch_q[k] <= posn_i[k*DW +: DW];
    end
  end

  always_comb begin
    snap_c = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (framing_enable_i && framing_mask_i[k]) begin
        case (framing_mode_i)
          FRAMING_DELTA: snap_c[k*DW +: DW] = posn_i[k*DW +: DW] - frame_latch_q[k];
          FRAMING_LATCH: snap_c[k*DW +: DW] = frame_latch_q[k];
          default:       snap_c[k*DW +: DW] = posn_i[k*DW +: DW];
        endcase
      end else begin
        snap_c[k*DW +: DW] = posn_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_o;
    load_c  = 1'b0;
    clear_c = 1'b0;
    done_c  = 1'b0;
    arm_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = ARMED;
          err_d   = ERR_OK;
          arm_c   = 1'b1;
        end
      end
      ARMED: begin
        if (disarm_i) begin
          state_d = IDLE;
          err_d   = ERR_DISARM;
          clear_c = 1'b1;
          done_c  = 1'b1;
        end else if (enable_rise_c) begin
          state_d = ENABLED;
        end
      end
      ENABLED: begin
        if (disarm_i) begin
          state_d = IDLE;
          err_d   = ERR_DISARM;
          clear_c = 1'b1;
          done_c  = 1'b1;
        end else begin
          if (capture_rise_c) begin
            if (busy_c) begin
              state_d = FLUSH;
              err_d   = ERR_OVERRUN;
            end else begin
              load_c = 1'b1;
            end
          end
          if (enable_fall_c) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (disarm_i) begin
          state_d = IDLE;
          err_d   = ERR_DISARM;
          clear_c = 1'b1;
          done_c  = 1'b1;
        end else if (!busy_c) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_o       <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= ERR_OK;
      sample_count_o <= '0;
    end else begin
      active_o <= (state_d != IDLE);
      done_o   <= done_c;
      err_o    <= err_d;
      if (arm_c) sample_count_o <= '0;
      else if (load_c && (sample_count_o != '1)) sample_count_o <= sample_count_o + CNT_W'(1);
    end
  end

  pcap_sample_serialiser #(
    .NCHAN (NCHAN),
    .DW    (DW)
  ) u_serialiser (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (clear_c),
    .load_i      (load_c),
    .data_i      (snap_c),
    .mask_i      (capture_mask_i),
    .dat_o       (dat_o),
    .dat_valid_o (dat_valid_o),
    .dat_ready_i (dat_ready_i),
    .busy_c      (busy_c)
  );

endmodule

// File: tb/tb_pcap_frame_capture.sv
// Self-checking bench for pcap_frame_capture: table of framed/unframed captures
// plus sequences for latency, overrun, disarm, re-arm, stress and reset.
module tb_pcap_frame_capture;
  import pcap_capture_pkg::*;

  localparam int unsigned NCHAN = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 32;

  logic                clk_i = 1'b0;
  logic                reset_i, arm_i, disarm_i, enable_i, frame_i, capture_i;
  logic [NCHAN*DW-1:0] posn_i;
  logic [NCHAN-1:0]    capture_mask_i, framing_mask_i;
  logic                framing_enable_i, framing_mode_i;
  logic [DW-1:0]       dat_o;
  logic                dat_valid_o, dat_ready_i;
  logic                active_o, done_o;
  logic [1:0]          err_o;
  logic [CNT_W-1:0]    sample_count_o;

  pcap_frame_capture #(.NCHAN(NCHAN), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .arm_i            (arm_i),
    .disarm_i         (disarm_i),
    .enable_i         (enable_i),
    .frame_i          (frame_i),
    .capture_i        (capture_i),
    .posn_i           (posn_i),
    .capture_mask_i   (capture_mask_i),
    .framing_mask_i   (framing_mask_i),
    .framing_enable_i (framing_enable_i),
    .framing_mode_i   (framing_mode_i),
    .dat_o            (dat_o),
    .dat_valid_o      (dat_valid_o),
    .dat_ready_i      (dat_ready_i),
    .active_o         (active_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .sample_count_o   (sample_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  cmask;
    logic        fen;
    logic        fmode;
    logic [7:0]  fmask;
    logic        do_frame;
    logic [31:0] frame_base;
    logic [31:0] cap_base;
    logic [31:0] exp_first;
    int          exp_n;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] exp_q [$];
  logic [31:0] posn_m [NCHAN];
  logic [31:0] latch_m [NCHAN];
  int          n_vec = 0;
  int          n_err = 0;
  int          words_seen = 0;
  logic        rand_ready = 1'b0;
  logic        ready_lvl = 1'b0;
  logic        held_vld = 1'b0;
  logic [31:0] held_dat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_posn(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < NCHAN; k++) begin
      posn_m[k] = base + 32'(k) * step;
      posn_i[k*32 +: 32] = posn_m[k];
    end
  endtask

  function automatic logic [31:0] model_word(input int k);
    if (framing_enable_i && framing_mask_i[k])
      return framing_mode_i ? latch_m[k] : posn_m[k] - latch_m[k];
    return posn_m[k];
  endfunction

  task automatic do_arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int k = 0; k < NCHAN; k++) latch_m[k] = '0;
  endtask

  task automatic do_disarm();
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
  endtask

  task automatic do_frame();
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    for (int k = 0; k < NCHAN; k++) latch_m[k] = posn_m[k];
    tick();
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || dat_valid_o) && n < max) begin
      tick();
      n++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done_o && n < max) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_o), 64'd1);
  endtask

  always @(posedge clk_i) begin
    #1;
    dat_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // Scoreboard: a transfer is counted where valid & ready hold ahead of the next edge.
  always @(negedge clk_i) begin
    if (reset_i) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld && dat_valid_o) check("hold_stable", 64'(dat_o), 64'(held_dat));
      if (dat_valid_o && dat_ready_i) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_word: got %0h expected none at %0t", dat_o, $time);
        end else begin
          check("word", 64'(dat_o), 64'(exp_q.pop_front()));
        end
      end
      held_vld = dat_valid_o && !dat_ready_i;
      held_dat = dat_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h0B, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0,          32'd0,    32'd0,          3};
    tbl[1] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 32'd1000,       32'd1250, 32'd250,        1};
    tbl[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 32'hFFFF_FFF0,  32'h10,   32'h20,         1};
    tbl[3] = '{8'h06, 1'b1, 1'b1, 8'hFF, 1'b1, 32'd500,        32'd900,  32'd600,        2};
    tbl[4] = '{8'h06, 1'b1, 1'b1, 8'h02, 1'b0, 32'd0,          32'd900,  32'd600,        2};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0,          32'd77,   32'd0,          0};
    tbl[6] = '{8'hFF, 1'b1, 1'b0, 8'hF0, 1'b1, 32'd10,         32'd5,    32'd5,          8};
    tbl[7] = '{8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0,          32'd7,    32'd707,        1};

    reset_i = 1'b1; arm_i = 1'b0; disarm_i = 1'b0; enable_i = 1'b0; frame_i = 1'b0;
    capture_i = 1'b0; capture_mask_i = '0; framing_mask_i = '0; framing_enable_i = 1'b0;
    framing_mode_i = 1'b0;
    set_posn(0, 100);
    repeat (3) tick();
    check("rst_valid", 64'(dat_valid_o), 0);
    check("rst_active", 64'(active_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_err", 64'(err_o), 0);
    check("rst_count", 64'(sample_count_o), 0);
    reset_i = 1'b0;
    ready_lvl = 1'b1;
    tick();

    // Basic capture: latency and ordering of mask 0x0B.
    capture_mask_i = 8'h0B;
    do_arm();
    check("active_after_arm", 64'(active_o), 1);
    enable_i = 1'b1;
    tick();
    capture_i = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd100); exp_q.push_back(32'd300);
    tick();
    capture_i = 1'b0;
    check("valid_at_t1", 64'(dat_valid_o), 0);
    check("count_one", 64'(sample_count_o), 1);
    tick();
    check("valid_at_t2", 64'(dat_valid_o), 1);
    check("first_word_t2", 64'(dat_o), 0);
    wait_drain(50);
    enable_i = 1'b0;
    tick();
    check("done_not_yet", 64'(done_o), 0);
    tick();
    check("done_pulse", 64'(done_o), 1);
    check("active_fall", 64'(active_o), 0);
    tick();
    check("done_single", 64'(done_o), 0);

    // Table of framed / unframed captures within one run.
    do_arm();
    check("count_cleared", 64'(sample_count_o), 0);
    enable_i = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      framing_enable_i = tbl[r].fen;
      framing_mode_i   = tbl[r].fmode;
      framing_mask_i   = tbl[r].fmask;
      capture_mask_i   = tbl[r].cmask;
      if (tbl[r].do_frame) begin
        set_posn(tbl[r].frame_base, 100);
        do_frame();
      end
      set_posn(tbl[r].cap_base, 100);
      begin
        bit first = 1'b1;
        for (int k = 0; k < NCHAN; k++) begin
          if (tbl[r].cmask[k]) begin
            exp_q.push_back(first ? tbl[r].exp_first : model_word(k));
            first = 1'b0;
          end
        end
      end
      words_seen = 0;
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      wait_drain(100);
      check("tbl_words", 64'(words_seen), 64'(tbl[r].exp_n));
      check("tbl_count", 64'(sample_count_o), 64'(r + 1));
    end
    enable_i = 1'b0;
    repeat (3) tick();

    // Frame and capture rising together: old latch used, new latch afterwards.
    framing_enable_i = 1'b1; framing_mode_i = 1'b1; framing_mask_i = 8'h01; capture_mask_i = 8'h01;
    do_arm();
    enable_i = 1'b1;
    tick();
    set_posn(7, 100);
    do_frame();
    set_posn(9, 100);
    frame_i = 1'b1; capture_i = 1'b1;
    exp_q.push_back(32'd7);
    tick();
    frame_i = 1'b0; capture_i = 1'b0;
    for (int k = 0; k < NCHAN; k++) latch_m[k] = posn_m[k];
    wait_drain(50);
    capture_i = 1'b1;
    exp_q.push_back(32'd9);
    tick();
    capture_i = 1'b0;
    wait_drain(50);
    enable_i = 1'b0;
    repeat (3) tick();

    // Stress: random backpressure, 150 captures.
    framing_enable_i = 1'b0; capture_mask_i = 8'hA5;
    do_arm();
    enable_i = 1'b1;
    tick();
    rand_ready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      for (int k = 0; k < NCHAN; k++) begin
        posn_m[k] = $urandom;
        posn_i[k*32 +: 32] = posn_m[k];
      end
      for (int k = 0; k < NCHAN; k++) if (capture_mask_i[k]) exp_q.push_back(posn_m[k]);
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      repeat (59) tick();
    end
    wait_drain(200);
    check("stress_err", 64'(err_o), 64'(ERR_OK));
    check("stress_count", 64'(sample_count_o), 150);
    enable_i = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done_o) begin
          pulses++;
          check("active_at_done", 64'(active_o), 0);
        end
      end
      check("stress_done_pulses", 64'(pulses), 1);
    end
    rand_ready = 1'b0;
    ready_lvl = 1'b0;
    tick();

    // Overrun under held-off ready, then drain and completion.
    capture_mask_i = 8'h03;
    do_arm();
    enable_i = 1'b1;
    tick();
    set_posn(50, 100);
    exp_q.push_back(32'd50); exp_q.push_back(32'd150);
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    repeat (3) tick();
    check("ovr_valid_held", 64'(dat_valid_o), 1);
    check("ovr_first", 64'(dat_o), 50);
    set_posn(999, 1);
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    check("ovr_err", 64'(err_o), 64'(ERR_OVERRUN));
    check("ovr_count", 64'(sample_count_o), 1);
    repeat (5) tick();
    check("ovr_no_done_yet", 64'(done_o), 0);
    ready_lvl = 1'b1;
    wait_done(50);
    check("ovr_active_off", 64'(active_o), 0);
    check("ovr_err_held", 64'(err_o), 64'(ERR_OVERRUN));
    check("ovr_queue_empty", 64'(exp_q.size()), 0);
    enable_i = 1'b0;
    tick();

    // Disarm while ARMED.
    do_arm();
    check("rearm_err_clear", 64'(err_o), 64'(ERR_OK));
    do_disarm();
    check("disarm_err", 64'(err_o), 64'(ERR_DISARM));
    check("disarm_done", 64'(done_o), 1);
    check("disarm_active", 64'(active_o), 0);
    tick();

    // Disarm with a word in flight drops it next cycle.
    ready_lvl = 1'b0;
    capture_mask_i = 8'h01;
    do_arm();
    enable_i = 1'b1;
    tick();
    exp_q.push_back(posn_m[0]);
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    repeat (3) tick();
    check("inflight_valid", 64'(dat_valid_o), 1);
    do_disarm();
    check("inflight_dropped", 64'(dat_valid_o), 0);
    check("inflight_err", 64'(err_o), 64'(ERR_DISARM));
    exp_q.delete();
    ready_lvl = 1'b1;
    tick();

    // Enable already high at arm never starts capture; count restarts per arm.
    for (int i = 0; i < 3; i++) begin
      do_arm();
      check("rearm_count", 64'(sample_count_o), 0);
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      repeat (3) tick();
      check("no_capture_without_rise", 64'(sample_count_o), 0);
      enable_i = 1'b0;
      tick();
      enable_i = 1'b1;
      tick();
      set_posn(32'(i * 10 + 3), 100);
      exp_q.push_back(posn_m[0]);
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      wait_drain(50);
      check("fresh_rise_count", 64'(sample_count_o), 1);
      do_disarm();
      tick();
    end

    // Reset mid-operation drops everything.
    ready_lvl = 1'b0;
    enable_i = 1'b0;
    do_arm();
    enable_i = 1'b1;
    tick();
    exp_q.push_back(posn_m[0]);
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b1;
    tick();
    check("mid_rst_valid", 64'(dat_valid_o), 0);
    check("mid_rst_active", 64'(active_o), 0);
    check("mid_rst_count", 64'(sample_count_o), 0);
    check("mid_rst_err", 64'(err_o), 0);
    exp_q.delete();
    reset_i = 1'b0;
    enable_i = 1'b0;
    repeat (3) tick();
    check("final_queue_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
